oled_fb_reader: RTL
===================

# oled_fb_reader

Display-side read stage between the 80x60 camera frame buffer (second read port) and the SPI OLED driver (`oled_video`, 96x64 RGB565). It tracks the driver's `x`/`y` scan position and issues frame-buffer read addresses. It converts the buffer's {r5,g5,b6} word to RGB565 and fills off-image pixels with a border colour. An optional tear-free mode holds camera writes while one OLED frame is scanned.

## Interface
- `IMG_COLS`, 80: image width in pixels
- `IMG_ROWS`, 60: image height in pixels
- `NB_ADDR`, 13: frame-buffer address width
- `OLED_COLS`, 96: OLED width
- `OLED_ROWS`, 64: OLED height
- `SWAP_RB`, 1: 1 = output {b5,g6,r5}; 0 = {r5,g6,b5}
- `BORDER`, 16'hFFFF: colour for off-image pixels

Ports:
- `clk`  in  1  system clock (50 MHz domain shared with capture and OLED)
- `rst_n`  in  1  synchronous, active-low reset
- `next_pixel`  in  1  one-cycle pulse from `oled_video`; `x`/`y` advance on the following cycle
- `x`  in  7  OLED column 0..95
- `y`  in  7  OLED row 0..63
- `fb_addr`  out  NB_ADDR  frame-buffer read address
- `fb_data`  in  16  frame-buffer word {r5,g5,b6}, valid 1 cycle after `fb_addr`
- `color`  out  16  pixel colour to `oled_video`
- `freeze_en`  in  1  enables tear-free mode
- `cap_frame_done`  in  1  one-cycle pulse when capture writes the last pixel (addr IMG_COLS*IMG_ROWS-1)
- `hold_capture`  out  1  1 = capture write enable must be gated off
- `frame_active`  out  1  1 while an OLED frame is being scanned under freeze

## Operation
- Address: `fb_addr = y*IMG_COLS + x` when x<IMG_COLS and y<IMG_ROWS. Compute it with shift-add ((y<<6)+(y<<4)+x for 80), not a multiplier. Range 0..4799, never exceeds IMG_COLS*IMG_ROWS-1. Off-image pixels hold the last in-window address.
- Pipeline: stage 1 registers `fb_addr` and `in_win` = (x<IMG_COLS && y<IMG_ROWS) from the current x/y. Stage 2 is the fb read. Stage 3 registers `color`.
- Conversion: r5=d[15:11], g6={d[10:6], d[10]}, b5=d[5:1]. Pack per SWAP_RB. `in_win`=0 gives `color`=BORDER.
- The pipeline runs every cycle, freely following x/y. It is independent of `next_pixel`.
- Tear-free FSM (only when `freeze_en`=1; otherwise stays in IDLE with `hold_capture`=0):
  - IDLE: on `next_pixel` with x=OLED_COLS-1, y=OLED_ROWS-1 (end of an OLED frame) -> WAIT_CAP.
  - WAIT_CAP: `hold_capture`=0. On `cap_frame_done` -> SCAN.
  - SCAN: `hold_capture`=1, `frame_active`=1. On end-of-OLED-frame `next_pixel` -> WAIT_CAP.
  - `freeze_en` deasserted in any state -> IDLE next cycle, with `hold_capture`=0 in the same next cycle.
- `cap_frame_done` in SCAN is ignored. Capture is gated, so it should not occur.
- If `cap_frame_done` and end-of-frame `next_pixel` occur in the same WAIT_CAP cycle, go to SCAN.

## Timing
- Reset (rst_n=0 at a clk edge): `fb_addr`=0, `color`=16'h0000, `hold_capture`=0, `frame_active`=0, state IDLE. Reset mid-scan aborts the scan and releases capture on the next edge.
- Latency from x/y change to valid `color` is 3 clk. `oled_video` spends ≥16 clk per pixel, so `color` is stable before the next `next_pixel`.
- `hold_capture` rises 1 clk after `cap_frame_done`. It falls 1 clk after the end-of-frame `next_pixel`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `ov7670_pkg`: image geometry (80/60/4800, 13-bit address), buffer field widths (5/5/6), RGB565 field positions, FSM state encodings (IDLE=0, WAIT_CAP=1, SCAN=2). The capture and VGA stages use the same constants.
- One sub-module is natural: `rgb_pack`, the registered {r5,g5,b6} -> RGB565 conversion with swap. Everything else is flat.

## Test plan
- x=0,y=0 -> fb_addr=0 after 1 clk. x=79,y=59 -> fb_addr=4799. x=5,y=2 -> fb_addr=165.
- fb_data=16'hF800 (r=31,g=0,b=0) in window, SWAP_RB=0 -> color=16'hF800. SWAP_RB=1 -> color=16'h001F. fb_data=16'h07C0 -> g6=6'h3F -> color=16'h07E0.
- x=80,y=10 and x=10,y=60 -> color=16'hFFFF, 3 clk after the x/y change.
- freeze_en=1: end-of-frame next_pixel, then cap_frame_done -> hold_capture=1 for one full 96x64 scan, then 0. A second cap_frame_done re-enters SCAN.
- freeze_en dropped mid-SCAN -> hold_capture=0 next clk, state IDLE. rst_n=0 mid-SCAN -> all outputs at reset values next clk.
- cap_frame_done coincident with end-of-frame next_pixel in WAIT_CAP -> state SCAN, hold_capture=1 next clk.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Constants shared by the camera capture, VGA and OLED read stages: frame
// geometry, frame-buffer word layout, RGB565 layout and tear-free FSM states.
package ov7670_pkg;

    localparam int FB_COLS   = 80;
    localparam int FB_ROWS   = 60;
    localparam int FB_PIXELS = FB_COLS * FB_ROWS;
    localparam int FB_ADDR_W = 13;

    // Frame-buffer word is {r5, g5, b6}
    localparam int FB_R_W = 5;
    localparam int FB_G_W = 5;
    localparam int FB_B_W = 6;

    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CAP = 2'd1,
        ST_SCAN     = 2'd2
    } freeze_state_e;

    // row*80 + col without a multiplier: (row<<6) + (row<<4) + col
    function automatic logic [FB_ADDR_W-1:0] pix_addr_80(input logic [6:0] row,
                                                         input logic [6:0] col);
        logic [FB_ADDR_W-1:0] r;
        r = {6'b0, row};
        return (r << 6) + (r << 4) + {6'b0, col};
    endfunction

endpackage

// File: rtl/rgb_pack.sv
// Registered conversion of a {r5,g5,b6} frame-buffer word to RGB565, with
// optional red/blue swap and a fixed border colour for off-image pixels.
module rgb_pack
    import ov7670_pkg::*;
#(
    parameter bit          SWAP_RB = 1'b1,
    parameter logic [15:0] BORDER  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data,
    input  logic        in_win,
    output logic [15:0] color
);

    logic [FB_R_W-1:0] r5;
    logic [FB_G_W-1:0] g5;
    logic [4:0]        b5;
    logic [5:0]        g6;
    logic [15:0]       color_next;
    logic              unused_b_lsb;

    assign r5 = data[15:11];
    assign g5 = data[10:6];
    // The blue LSB is dropped to fit RGB565; green is widened by repeating its MSB
    assign b5 = data[5:1];
    assign g6 = {g5, g5[FB_G_W-1]};
    assign unused_b_lsb = data[0];

    always_comb begin
        color_next = BORDER;
        if (in_win) begin
            color_next[RGB_R_LSB +: 5] = SWAP_RB ? b5 : r5;
            color_next[RGB_G_LSB +: 6] = g6;
            color_next[RGB_B_LSB +: 5] = SWAP_RB ? r5 : b5;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            color <= 16'h0000;
        end else begin
            color <= color_next;
        end
    end

endmodule

// File: rtl/oled_fb_reader.sv
// OLED-side frame-buffer reader: follows the driver's x/y, fetches image pixels,
// converts them to RGB565, and optionally holds capture during an OLED scan.
module oled_fb_reader
    import ov7670_pkg::*;
#(
    parameter int unsigned IMG_COLS  = 80,
    parameter int unsigned IMG_ROWS  = 60,
    parameter int unsigned NB_ADDR   = 13,
    parameter int unsigned OLED_COLS = 96,
    parameter int unsigned OLED_ROWS = 64,
    parameter bit          SWAP_RB   = 1'b1,
    parameter logic [15:0] BORDER    = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               next_pixel,
    input  logic [6:0]         x,
    input  logic [6:0]         y,
    output logic [NB_ADDR-1:0] fb_addr,
    input  logic [15:0]        fb_data,
    output logic [15:0]        color,
    input  logic               freeze_en,
    input  logic               cap_frame_done,
    output logic               hold_capture,
    output logic               frame_active,
    output freeze_state_e      state
);

    localparam logic [6:0] COLS7  = 7'(IMG_COLS);
    localparam logic [6:0] ROWS7  = 7'(IMG_ROWS);
    localparam logic [6:0] LAST_X = 7'(OLED_COLS - 1);
    localparam logic [6:0] LAST_Y = 7'(OLED_ROWS - 1);

    logic [NB_ADDR-1:0] addr_next;
    logic               in_win_next;
    logic               in_win_s1;
    logic               in_win_s2;
    logic               end_of_frame;

    if (IMG_COLS == 80) begin : g_shift_add
        assign addr_next = NB_ADDR'(pix_addr_80(y, x));
    end else begin : g_mult
        assign addr_next = NB_ADDR'(32'(y) * IMG_COLS + 32'(x));
    end

    assign in_win_next  = (x < COLS7) && (y < ROWS7);
    assign end_of_frame = next_pixel && (x == LAST_X) && (y == LAST_Y);

    // Free-running pipeline: address/window flag, external fb read, colour.
    // in_win is delayed twice so it lines up with fb_data one cycle after fb_addr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_addr   <= '0;
            in_win_s1 <= 1'b0;
            in_win_s2 <= 1'b0;
        end else begin
            if (in_win_next) begin
                fb_addr <= addr_next;
            end
            in_win_s1 <= in_win_next;
            in_win_s2 <= in_win_s1;
        end
    end

    rgb_pack #(
        .SWAP_RB (SWAP_RB),
        .BORDER  (BORDER)
    ) u_rgb_pack (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (fb_data),
        .in_win (in_win_s2),
        .color  (color)
    );

    // Tear-free control: capture may run only between OLED frames; once a full
    // camera frame lands, capture is held for exactly one OLED scan.
    always_ff @(posedge clk) begin
        if (!rst_n || !freeze_en) begin
            state        <= ST_IDLE;
            hold_capture <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (end_of_frame) begin
                        state <= ST_WAIT_CAP;
                    end
                end
                ST_WAIT_CAP: begin
                    if (cap_frame_done) begin
                        state        <= ST_SCAN;
                        hold_capture <= 1'b1;
                        frame_active <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (end_of_frame) begin
                        state        <= ST_WAIT_CAP;
                        hold_capture <= 1'b0;
                        frame_active <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    hold_capture <= 1'b0;
                    frame_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
